// File: rtl/pdp8_panel_pkg.sv
// pdp8_panel_pkg: shared button indices, sequencer states and status bit positions
package pdp8_panel_pkg;
    localparam int BTN_LOADADDR = 0;
    localparam int BTN_DEPOSIT  = 1;
    localparam int BTN_EXAMINE  = 2;
    localparam int BTN_CONT     = 3;
    localparam int BTN_STOP     = 4;
    localparam int BTN_STEP     = 5;
    localparam int Y_RUN  = 0;
    localparam int Y_BUSY = 1;
    localparam int Y_DEP  = 2;
    localparam int Y_EXAM = 3;
    typedef enum logic [2:0] {S_IDLE, S_MEMRD, S_MEMWR, S_RUN, S_STEP, S_STOPWAIT} state_t;
endpackage

// File: rtl/panel_debounce.sv
// panel_debounce: release holdoff counter and priority encoder yielding a single accepted press
module panel_debounce
    import pdp8_panel_pkg::*;
#(
    parameter int HOLDOFF = 4096
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] buttons,
    input  logic       enable,
    output logic       press,
    output logic [2:0] index
);
    localparam int CW = $clog2(HOLDOFF + 1) < 12 ? 12 : $clog2(HOLDOFF + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge CLK) begin
        if (RESET) cnt <= CW'(HOLDOFF);
        else if (|buttons) cnt <= '0;
        else if (cnt != CW'(HOLDOFF)) cnt <= cnt + 1'b1;
    end
    // STOP > LOAD ADDR > DEPOSIT > EXAMINE > SINGLE STEP > CONT
    always_comb begin
        index = buttons[BTN_STOP]     ? 3'(BTN_STOP) :
                buttons[BTN_LOADADDR] ? 3'(BTN_LOADADDR) :
                buttons[BTN_DEPOSIT]  ? 3'(BTN_DEPOSIT) :
                buttons[BTN_EXAMINE]  ? 3'(BTN_EXAMINE) :
                buttons[BTN_STEP]     ? 3'(BTN_STEP) : 3'(BTN_CONT);
        press = enable && (|buttons) && (cnt == CW'(HOLDOFF));
    end
endmodule

// File: rtl/panel_sequencer.sv
// panel_sequencer: front-panel command FSM driving the panel memory port, CPU run/step and display words
module panel_sequencer
    import pdp8_panel_pkg::*;
#(
    parameter int HOLDOFF = 4096
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [11:0] switches,
    input  logic [5:0]  buttons,
    input  logic        cpu_halted,
    input  logic [11:0] cpu_pc,
    output logic        cpu_run,
    output logic        cpu_step,
    output logic        cpu_pc_load,
    output logic        mem_req,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [11:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [11:0] mem_rdata,
    output logic [11:0] green,
    output logic [11:0] red,
    output logic [11:0] yellow
);
    state_t      state, state_d;
    logic [11:0] ma, mb;
    logic        dep, exam, halted_q, press, idle, halt_rise, load;
    logic [1:0]  step_cnt;
    logic [2:0]  idx;
    panel_debounce #(.HOLDOFF(HOLDOFF)) u_debounce (
        .CLK    (CLK),
        .RESET  (RESET),
        .buttons(buttons),
        .enable (state == S_IDLE || state == S_RUN),
        .press  (press),
        .index  (idx)
    );
    always_comb begin
        idle      = state == S_IDLE;
        halt_rise = cpu_halted && !halted_q;
        load      = idle && press && idx == 3'(BTN_LOADADDR);
        state_d   = state;
        case (state)
            S_IDLE:
                if (press)
                    state_d = idx == 3'(BTN_DEPOSIT) ? S_MEMWR :
                              idx == 3'(BTN_EXAMINE) ? S_MEMRD :
                              idx == 3'(BTN_CONT)    ? S_RUN :
                              idx == 3'(BTN_STEP)    ? S_STEP : S_IDLE;
            S_MEMRD, S_MEMWR: state_d = mem_ack ? S_IDLE : state;
            // a HLT seen while running wins over a simultaneous STOP
            S_RUN: state_d = halt_rise ? S_IDLE : (press && idx == 3'(BTN_STOP)) ? S_STOPWAIT : S_RUN;
            S_STEP: state_d = (cpu_halted && step_cnt == 2'd2) ? S_IDLE : S_STEP;
            S_STOPWAIT: state_d = cpu_halted ? S_IDLE : S_STOPWAIT;
            default: state_d = S_IDLE;
        endcase
        mem_req  = state == S_MEMRD || state == S_MEMWR;
        mem_we   = state == S_MEMWR;
        mem_addr = ma;
        green    = cpu_run ? cpu_pc : ma;
        red      = mb;
        yellow         = '0;
        yellow[Y_RUN]  = cpu_run;
        yellow[Y_BUSY] = !idle && state != S_RUN;
        yellow[Y_DEP]  = dep;
        yellow[Y_EXAM] = exam;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            ma          <= '0;
            mb          <= '0;
            mem_wdata   <= '0;
            cpu_run     <= 1'b0;
            cpu_step    <= 1'b0;
            cpu_pc_load <= 1'b0;
            dep         <= 1'b0;
            exam        <= 1'b0;
            halted_q    <= 1'b0;
            step_cnt    <= '0;
        end else begin
            state       <= state_d;
            halted_q    <= cpu_halted;
            cpu_run     <= state_d == S_RUN;
            cpu_step    <= idle && state_d == S_STEP;
            cpu_pc_load <= load;
            // counts cycles since the step pulse so the halt check skips the stale halted level
            step_cnt    <= state != S_STEP ? 2'd0 : step_cnt == 2'd2 ? step_cnt : step_cnt + 2'd1;
            if (load) ma <= switches;
            if (mem_req && mem_ack) ma <= ma + 12'd1;
            if (state == S_MEMRD && mem_ack) mb <= mem_rdata;
            if (idle && state_d == S_MEMWR) begin
                mem_wdata <= switches;
                mb        <= switches;
                dep       <= 1'b1;
                exam      <= 1'b0;
            end
            if (idle && state_d == S_MEMRD) begin
                dep  <= 1'b0;
                exam <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_panel_sequencer.sv
// tb_panel_sequencer: directed panel operations checked against a cycle model plus literal expectations
module tb_panel_sequencer;
    localparam int HOLDOFF = 8;
    logic        CLK = 1'b0, RESET = 1'b1;
    logic [11:0] switches = '0, cpu_pc = '0, mem_rdata = '0;
    logic [5:0]  buttons = '0;
    logic        cpu_halted = 1'b0, mem_ack = 1'b0;
    logic        cpu_run, cpu_step, cpu_pc_load, mem_req, mem_we;
    logic [11:0] mem_addr, mem_wdata, green, red, yellow;
    int total = 0, bad = 0;
    bit chk_en = 0;

    panel_sequencer #(.HOLDOFF(HOLDOFF)) dut (
        .CLK(CLK), .RESET(RESET), .switches(switches), .buttons(buttons),
        .cpu_halted(cpu_halted), .cpu_pc(cpu_pc), .cpu_run(cpu_run), .cpu_step(cpu_step),
        .cpu_pc_load(cpu_pc_load), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .green(green), .red(red), .yellow(yellow)
    );

    always #5 CLK = ~CLK;

    // model: mode names are the panel's visible activities
    localparam int M_IDLE = 0, M_READ = 1, M_WRITE = 2, M_RUN = 3, M_STEP = 4, M_STOP = 5;
    int prio[6] = '{4, 0, 1, 2, 5, 3};
    int m_mode, m_quiet, m_since, pick;
    bit m_run, m_step, m_pcl, m_dep, m_exam, m_hprev, acc;
    logic [11:0] m_ma, m_mb, m_wd;

    always @(posedge CLK) begin
        if (RESET) begin
            m_mode = M_IDLE; m_quiet = HOLDOFF; m_since = 0;
            m_run = 0; m_step = 0; m_pcl = 0; m_dep = 0; m_exam = 0; m_hprev = 0;
            m_ma = 0; m_mb = 0; m_wd = 0;
        end else begin
            pick = -1;
            for (int i = 0; i < 6; i++) if (pick < 0 && buttons[prio[i]]) pick = prio[i];
            acc = (m_mode == M_IDLE || m_mode == M_RUN) && buttons != 0 && m_quiet >= HOLDOFF;
            m_quiet = buttons != 0 ? 0 : m_quiet + 1;
            m_step = 0; m_pcl = 0;
            if (m_mode == M_IDLE && acc) begin
                if (pick == 0) begin m_ma = switches; m_pcl = 1; end
                else if (pick == 1) begin m_wd = switches; m_mb = switches; m_dep = 1; m_exam = 0; m_mode = M_WRITE; end
                else if (pick == 2) begin m_dep = 0; m_exam = 1; m_mode = M_READ; end
                else if (pick == 3) m_mode = M_RUN;
                else if (pick == 5) begin m_step = 1; m_since = 0; m_mode = M_STEP; end
            end else if (m_mode == M_READ && mem_ack) begin
                m_mb = mem_rdata; m_ma = m_ma + 1; m_mode = M_IDLE;
            end else if (m_mode == M_WRITE && mem_ack) begin
                m_ma = m_ma + 1; m_mode = M_IDLE;
            end else if (m_mode == M_RUN) begin
                if (cpu_halted && !m_hprev) m_mode = M_IDLE;
                else if (acc && pick == 4) m_mode = M_STOP;
            end else if (m_mode == M_STEP) begin
                if (m_since >= 2 && cpu_halted) m_mode = M_IDLE;
                m_since++;
            end else if (m_mode == M_STOP && cpu_halted) m_mode = M_IDLE;
            m_hprev = cpu_halted;
            m_run = m_mode == M_RUN;
        end
    end

    logic [64:0] act_v, exp_v;
    always @(negedge CLK) begin
        if (chk_en) begin
            act_v = {cpu_run, cpu_step, cpu_pc_load, mem_req, mem_we, mem_addr, mem_wdata, green, red, yellow};
            exp_v = {m_run, m_step, m_pcl, m_mode == M_READ || m_mode == M_WRITE, m_mode == M_WRITE,
                     m_ma, m_wd, m_run ? cpu_pc : m_ma, m_mb,
                     8'd0, m_exam, m_dep, m_mode != M_IDLE && m_mode != M_RUN, m_run};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, act_v, exp_v);
            end
        end
    end

    task automatic tk();
        @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [5:0] b);
        buttons = b;
        tk();
        buttons = '0;
    endtask

    task automatic quiet();
        repeat (HOLDOFF + 2) tk();
    endtask

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%o want=%o", name, got, want);
        end
    endtask

    initial begin
        tk();
        chk_en = 1;
        tk();
        RESET = 0;
        chk("reset_green", green, 12'o0);
        chk("reset_red", red, 12'o0);
        chk("reset_yellow", yellow, 12'o0);
        chk("reset_req", {11'd0, mem_req}, 12'd0);
        // LOAD ADDR straight after reset
        switches = 12'o1234;
        press(6'b000001);
        chk("pcload_pulse", {11'd0, cpu_pc_load}, 12'd1);
        chk("load_green", green, 12'o1234);
        tk();
        chk("pcload_width", {11'd0, cpu_pc_load}, 12'd0);
        quiet();
        // DEPOSIT at 7777 wraps MA
        switches = 12'o7777;
        press(6'b000001);
        quiet();
        switches = 12'o0055;
        press(6'b000010);
        switches = 12'o7070;
        chk("dep_we", {11'd0, mem_we}, 12'd1);
        chk("dep_addr", mem_addr, 12'o7777);
        chk("dep_wdata", mem_wdata, 12'o0055);
        tk(); tk();
        chk("dep_wdata_hold", mem_wdata, 12'o0055);
        mem_ack = 1; tk(); mem_ack = 0;
        chk("dep_wrap", green, 12'o0000);
        chk("dep_red", red, 12'o0055);
        chk("dep_yellow", yellow, 12'o0004);
        quiet();
        // EXAMINE at 0200
        switches = 12'o0200;
        press(6'b000001);
        quiet();
        press(6'b000100);
        tk();
        mem_rdata = 12'o7402; mem_ack = 1; tk(); mem_ack = 0;
        chk("exam_red", red, 12'o7402);
        chk("exam_green", green, 12'o0201);
        chk("exam_req_low", {11'd0, mem_req}, 12'd0);
        chk("exam_yellow", yellow, 12'o0010);
        mem_ack = 1; tk(); mem_ack = 0;
        chk("stray_ack", green, 12'o0201);
        quiet();
        // CONT then STOP, CPU halts 5 cycles later
        cpu_pc = 12'o4321;
        press(6'b001000);
        chk("run_on", {11'd0, cpu_run}, 12'd1);
        chk("run_green", green, 12'o4321);
        quiet();
        press(6'b010000);
        chk("stop_run_off", {11'd0, cpu_run}, 12'd0);
        chk("stop_busy", yellow & 12'o2, 12'o2);
        repeat (4) tk();
        chk("stopwait_busy", yellow & 12'o2, 12'o2);
        cpu_halted = 1;
        tk();
        chk("stop_idle", yellow & 12'o2, 12'o0);
        quiet();
        // SINGLE STEP with halted already high
        press(6'b100000);
        chk("step_pulse", {11'd0, cpu_step}, 12'd1);
        tk();
        chk("step_width", {11'd0, cpu_step}, 12'd0);
        tk();
        chk("step_busy", yellow & 12'o2, 12'o2);
        tk();
        chk("step_done", yellow & 12'o2, 12'o0);
        // HLT rise while running
        cpu_halted = 0;
        quiet();
        press(6'b001000);
        repeat (3) tk();
        cpu_halted = 1;
        tk();
        chk("hlt_run_off", {11'd0, cpu_run}, 12'd0);
        quiet();
        // simultaneous DEPOSIT+EXAMINE, then early EXAMINE ignored
        switches = 12'o3333;
        press(6'b000110);
        chk("prio_we", {11'd0, mem_we}, 12'd1);
        buttons = 6'b000100;
        tk();
        buttons = '0; mem_ack = 1; tk(); mem_ack = 0;
        press(6'b000100);
        chk("early_ignored", {11'd0, mem_req}, 12'd0);
        chk("prio_red", red, 12'o3333);
        quiet();
        // RESET during MEMWR, late ack ignored
        switches = 12'o1111;
        press(6'b000010);
        RESET = 1;
        tk();
        chk("rst_req", {11'd0, mem_req}, 12'd0);
        chk("rst_ma", green, 12'o0);
        RESET = 0; mem_ack = 1;
        tk();
        mem_ack = 0;
        chk("late_ack_req", {11'd0, mem_req}, 12'd0);
        chk("late_ack_ma", green, 12'o0);
        chk("late_ack_red", red, 12'o0);
        repeat (2) tk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/panel_sequencer.md
# panel_sequencer

Front-panel command sequencer for the PDP-8 core. It takes the latched switch register and the six panel buttons and turns button presses into LOAD ADDR, DEPOSIT, EXAMINE, CONT, STOP and SINGLE STEP operations. It owns the panel side of the memory port and the CPU run/step control, and it produces the green/red/yellow display words for the LED scanner. The block sits between the front-panel scanner and the CPU/memory.

## Interface
Parameters:
- HOLDOFF, 4096: cycles a button must read released before another press is accepted (debounce).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- switches  in  12  switch register from the panel scanner; may change at any cycle.
- buttons  in  6  raw button levels, 1 = pressed.
  - [0] LOAD ADDR, [1] DEPOSIT, [2] EXAMINE, [3] CONT, [4] STOP, [5] SINGLE STEP.
- cpu_halted  in  1  CPU is stopped at an instruction boundary.
- cpu_pc  in  12  CPU PC, shown on green while running.
- cpu_run  out  1  level; CPU free-runs while high.
- cpu_step  out  1  one-cycle pulse; CPU executes one instruction.
- cpu_pc_load  out  1  one-cycle pulse; CPU loads PC from mem_addr.
- mem_req  out  1  panel memory request.
- mem_we  out  1  write qualifier, valid with mem_req.
- mem_addr  out  12  panel address register (MA).
- mem_wdata  out  12  write data.
- mem_ack  in  1  one-cycle completion strobe; mem_rdata valid in the same cycle.
- mem_rdata  in  12  read data.
- green  out  12  MA when halted, cpu_pc when running.
- red  out  12  MB, the last deposited or examined word.
- yellow  out  12  status: [0] run, [1] busy, [2] last op deposit, [3] last op examine, [11:4] zero.

## Operation
- Press detection: a button is accepted when the state is IDLE or RUN, it reads 1, and all buttons have read 0 for at least HOLDOFF consecutive cycles.
  - Simultaneous presses resolve by priority STOP > LOAD ADDR > DEPOSIT > EXAMINE > SINGLE STEP > CONT. Only one command is accepted; the others are ignored.
- States: IDLE, MEMRD, MEMWR, RUN, STEP, STOPWAIT.
- IDLE, LOAD ADDR: MA <= switches; cpu_pc_load pulses. Stay in IDLE.
- IDLE, DEPOSIT: mem_wdata <= switches; MB <= switches; go to MEMWR.
  - On mem_ack: MA <= MA+1 (12-bit wrap, 7777→0000), then IDLE.
- IDLE, EXAMINE: go to MEMRD.
  - On mem_ack: MB <= mem_rdata; MA <= MA+1 (wraps), then IDLE.
- IDLE, CONT: cpu_run <= 1, go to RUN.
- IDLE, SINGLE STEP: cpu_step pulses one cycle, go to STEP.
- STEP: wait for cpu_halted == 1 at least 2 cycles after the pulse, then IDLE.
- RUN:
  - Only STOP is accepted; go to STOPWAIT and drop cpu_run.
  - If cpu_halted rises (HLT instruction), drop cpu_run and go to IDLE.
- STOPWAIT: wait for cpu_halted, then IDLE.
- Presses in MEMRD, MEMWR, STEP or STOPWAIT are discarded, but they still reset the holdoff counter.
- mem_req is high exactly in MEMRD/MEMWR. mem_we is high only in MEMWR.
- mem_addr and mem_wdata are stable while mem_req is high.
- yellow[1] (busy) = state is not IDLE and not RUN.

## Timing
- Reset values: state IDLE; MA = 0; MB = 0; all outputs 0; holdoff counter saturated, so the first press after reset is accepted.
- Press accept to action: 1 cycle (registered). cpu_pc_load and cpu_step are exactly 1 cycle wide.
- Memory handshake:
  - mem_req rises the cycle after acceptance and falls the cycle after mem_ack.
  - mem_ack with mem_req low is ignored.
  - No timeout; the block waits indefinitely.
- cpu_run changes one cycle after the triggering press or cpu_halted edge.
- RESET mid-operation (any state) returns to the reset values on the next edge. An outstanding memory request is abandoned, with mem_req low from that edge.
- Holdoff counter: 12+ bits, saturating at HOLDOFF; it clears on any buttons != 0.

## Structure
- Shared package pdp8_panel_pkg: button index constants (BTN_LOADADDR..BTN_STEP), state enum, yellow bit positions.
- Sub-module panel_debounce: holdoff counter plus priority one-hot press encoder, outputting a one-cycle press pulse and an index. The FSM, MA/MB registers and display muxing stay in panel_sequencer.

## Test plan
- Reset with HOLDOFF=8, switches=0o1234, press LOAD ADDR → cpu_pc_load one-cycle pulse; green=0o1234.
- MA=0o7777, switches=0o0055, DEPOSIT, mem_ack after 3 cycles → mem_we=1, mem_addr=0o7777, mem_wdata=0o0055; then MA=0o0000 (wrap), red=0o0055.
- MA=0o0200, EXAMINE, mem_ack with rdata=0o7402 → red=0o7402, green=0o0201, mem_req low the next cycle.
- CONT, then STOP with cpu_halted asserted 5 cycles later → cpu_run 1→0 on the STOP cycle+1; state returns to IDLE after cpu_halted; the yellow[1] busy bit is high only during the wait.
- Press DEPOSIT and EXAMINE in the same cycle, then press EXAMINE again before HOLDOFF has elapsed → only the deposit occurs; the second press is ignored.
- RESET asserted during MEMWR before mem_ack → next cycle mem_req=0 and MA=0; a late mem_ack is ignored.
